// File: rtl/wordle_guess_entry.sv
// Wordle guess assembly and scoring: collects five letters from the keyboard stage,
// scores a submitted guess green/yellow/gray against the secret word and tracks attempts.
module wordle_guess_entry #(
    parameter int MAX_GUESSES = 6,
    parameter int WORD_LEN    = 5
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        Ack,
    input  logic [7:0]  letter_in,
    input  logic        letter_valid,
    input  logic        del,
    input  logic        submit,
    input  logic [39:0] target_word,
    output logic [39:0] guess_word,
    output logic [2:0]  col_idx,
    output logic [2:0]  row_idx,
    output logic [9:0]  result,
    output logic        result_valid,
    output logic        win,
    output logic        done,
    output logic        q_I,
    output logic        q_Entry,
    output logic        q_Eval,
    output logic        q_Done
);
    // state  | meaning
    // QI     | idle, waiting for Start
    // QENTRY | collecting letters / delete / submit
    // QEVAL  | 7-cycle scoring: green pass, five yellow passes, publish
    // QDONE  | game over, waiting for Ack
    localparam logic [1:0] QI     = 2'd0;
    localparam logic [1:0] QENTRY = 2'd1;
    localparam logic [1:0] QEVAL  = 2'd2;
    localparam logic [1:0] QDONE  = 2'd3;

    localparam logic [39:0] SPACES   = {5{8'h20}};
    localparam logic [2:0]  LAST_ROW = 3'(MAX_GUESSES - 1);
    localparam logic [2:0]  FULL     = 3'(WORD_LEN);

    logic [1:0]  state;
    logic [2:0]  eval_cnt;
    logic [39:0] target_q;
    logic [4:0]  green;
    logic [4:0]  used;

    logic [4:0]  green_now;
    logic [2:0]  yel_pos;
    logic [7:0]  yel_letter;
    logic        yel_hit;
    logic [2:0]  yel_j;
    logic        letter_ok;

    assign letter_ok = (letter_in >= 8'h41) && (letter_in <= 8'h5A);

    always_comb begin
        green_now  = '0;
        yel_pos    = eval_cnt - 3'd1;
        yel_letter = 8'h00;
        yel_hit    = 1'b0;
        yel_j      = 3'd0;
        for (int i = 0; i < WORD_LEN; i++) begin
            green_now[i] = (guess_word[39-8*i -: 8] == target_q[39-8*i -: 8]);
            if (yel_pos == 3'(i))
                yel_letter = guess_word[39-8*i -: 8];
        end
        // Scan downward so the lowest matching unused target slot wins.
        for (int j = WORD_LEN - 1; j >= 0; j--) begin
            if (!used[j] && (target_q[39-8*j -: 8] == yel_letter)) begin
                yel_hit = 1'b1;
                yel_j   = 3'(j);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state        <= QI;
            eval_cnt     <= 3'd0;
            target_q     <= '0;
            green        <= '0;
            used         <= '0;
            guess_word   <= SPACES;
            col_idx      <= 3'd0;
            row_idx      <= 3'd0;
            result       <= '0;
            result_valid <= 1'b0;
            win          <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                QI: begin
                    if (Start) begin
                        target_q   <= target_word;
                        guess_word <= SPACES;
                        col_idx    <= 3'd0;
                        row_idx    <= 3'd0;
                        result     <= '0;
                        win        <= 1'b0;
                        green      <= '0;
                        used       <= '0;
                        state      <= QENTRY;
                    end
                end
                QENTRY: begin
                    if (del) begin
                        if (col_idx != 3'd0) begin
                            col_idx <= col_idx - 3'd1;
                            for (int i = 0; i < WORD_LEN; i++)
                                if (col_idx - 3'd1 == 3'(i))
                                    guess_word[39-8*i -: 8] <= 8'h20;
                        end
                    end else if (submit) begin
                        if (col_idx == FULL) begin
                            eval_cnt <= 3'd0;
                            state    <= QEVAL;
                        end
                    end else if (letter_valid && letter_ok && col_idx < FULL) begin
                        col_idx <= col_idx + 3'd1;
                        for (int i = 0; i < WORD_LEN; i++)
                            if (col_idx == 3'(i))
                                guess_word[39-8*i -: 8] <= letter_in;
                    end
                end
                QEVAL: begin
                    eval_cnt <= eval_cnt + 3'd1;
                    if (eval_cnt == 3'd0) begin
                        green <= green_now;
                        used  <= green_now;
                        for (int i = 0; i < WORD_LEN; i++)
                            result[9-2*i -: 2] <= green_now[i] ? 2'b11 : 2'b01;
                    end else if (eval_cnt <= 3'd5) begin
                        if (!green[yel_pos] && yel_hit) begin
                            used[yel_j] <= 1'b1;
                            for (int i = 0; i < WORD_LEN; i++)
                                if (yel_pos == 3'(i))
                                    result[9-2*i -: 2] <= 2'b10;
                        end
                    end else begin
                        result_valid <= 1'b1;
                        win          <= &green;
                        eval_cnt     <= 3'd0;
                        if ((&green) || row_idx == LAST_ROW) begin
                            state <= QDONE;
                        end else begin
                            row_idx    <= row_idx + 3'd1;
                            col_idx    <= 3'd0;
                            guess_word <= SPACES;
                            state      <= QENTRY;
                        end
                    end
                end
                QDONE: begin
                    if (Ack)
                        state <= QI;
                end
                default: state <= QI;
            endcase
        end
    end

    assign q_I     = (state == QI);
    assign q_Entry = (state == QENTRY);
    assign q_Eval  = (state == QEVAL);
    assign q_Done  = (state == QDONE);
    assign done    = q_Done;

endmodule

// File: tb/tb_wordle_guess_entry.sv
// Directed self-checking bench for wordle_guess_entry.
module tb_wordle_guess_entry;
    logic        Clk = 1'b0;
    logic        reset, Start, Ack, letter_valid, del, submit;
    logic [7:0]  letter_in;
    logic [39:0] target_word, guess_word;
    logic [2:0]  col_idx, row_idx;
    logic [9:0]  result;
    logic        result_valid, win, done, q_I, q_Entry, q_Eval, q_Done;

    int checks = 0;
    int failures = 0;
    int lat;

    wordle_guess_entry #(.MAX_GUESSES(6), .WORD_LEN(5)) dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack),
        .letter_in(letter_in), .letter_valid(letter_valid), .del(del), .submit(submit),
        .target_word(target_word), .guess_word(guess_word), .col_idx(col_idx),
        .row_idx(row_idx), .result(result), .result_valid(result_valid), .win(win),
        .done(done), .q_I(q_I), .q_Entry(q_Entry), .q_Eval(q_Eval), .q_Done(q_Done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic start_game(input logic [39:0] w);
        target_word = w;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic press(input logic [7:0] l);
        letter_in = l;
        letter_valid = 1'b1;
        tick();
        letter_valid = 1'b0;
    endtask

    task automatic press_del();
        del = 1'b1;
        tick();
        del = 1'b0;
    endtask

    task automatic enter_word(input logic [39:0] w);
        for (int i = 0; i < 5; i++) press(w[39-8*i -: 8]);
    endtask

    // Submits, then counts edges until result_valid rises (bounded); lat=99 on timeout.
    task automatic submit_and_wait(output int n);
        submit = 1'b1;
        tick();
        submit = 1'b0;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (result_valid) break;
        end
        if (!result_valid) n = 99;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (q_I !== 1'b1) begin failures++; $display("FAIL reset_q_I got=%b exp=1", q_I); end
        checks++; if (guess_word !== {5{8'h20}}) begin failures++; $display("FAIL reset_guess got=%h exp=%h", guess_word, {5{8'h20}}); end
        checks++; if ({col_idx, row_idx} !== 6'd0) begin failures++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", col_idx, row_idx); end
        checks++; if ({result, result_valid, win, done} !== 13'd0) begin failures++; $display("FAIL reset_outs got=%h/%b/%b/%b exp=0", result, result_valid, win, done); end
    endtask

    task automatic test_crane_win();
        logic [39:0] w = "CRANE";
        start_game(w);
        checks++; if (q_Entry !== 1'b1) begin failures++; $display("FAIL crane_entry got=%b exp=1", q_Entry); end
        enter_word(w);
        press("X");
        checks++; if (guess_word !== w || col_idx !== 3'd5) begin failures++; $display("FAIL crane_full got=%h/%0d exp=%h/5", guess_word, col_idx, w); end
        submit_and_wait(lat);
        checks++; if (lat !== 7) begin failures++; $display("FAIL crane_latency got=%0d exp=7", lat); end
        checks++; if (result !== 10'h3FF || win !== 1'b1) begin failures++; $display("FAIL crane_result got=%b/%b exp=1111111111/1", result, win); end
        checks++; if (done !== 1'b1 || q_Done !== 1'b1) begin failures++; $display("FAIL crane_done got=%b/%b exp=1/1", done, q_Done); end
        tick();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL crane_pulse_width got=%b exp=0", result_valid); end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        checks++; if (q_I !== 1'b1 || done !== 1'b0 || win !== 1'b1 || result !== 10'h3FF) begin failures++; $display("FAIL crane_ack got=%b/%b/%b/%h exp=1/0/1/3ff", q_I, done, win, result); end
    endtask

    task automatic test_delete();
        start_game("CRANE");
        press_del();
        checks++; if (col_idx !== 3'd0) begin failures++; $display("FAIL del_empty got=%0d exp=0", col_idx); end
        press("A"); press("B"); press("C");
        press_del(); press_del();
        press("D");
        press(8'h61);
        checks++; if (guess_word !== {"AD", 24'h202020} || col_idx !== 3'd2) begin failures++; $display("FAIL del_word got=%h/%0d exp=%h/2", guess_word, col_idx, {"AD", 24'h202020}); end
        submit = 1'b1;
        tick();
        submit = 1'b0;
        checks++; if (q_Entry !== 1'b1 || col_idx !== 3'd2) begin failures++; $display("FAIL del_submit_short got=%b/%0d exp=1/2", q_Entry, col_idx); end
    endtask

    task automatic test_duplicates();
        do_reset();
        start_game("APPLE");
        enter_word("PAPPY");
        submit_and_wait(lat);
        checks++; if (result !== 10'b10_10_11_01_01 || win !== 1'b0) begin failures++; $display("FAIL dup_pappy got=%b/%b exp=1010110101/0", result, win); end
        checks++; if (q_Entry !== 1'b1 || row_idx !== 3'd1 || col_idx !== 3'd0 || guess_word !== {5{8'h20}}) begin failures++; $display("FAIL dup_next_row got=%b/%0d/%0d/%h", q_Entry, row_idx, col_idx, guess_word); end
        do_reset();
        start_game("ABBEY");
        enter_word("BBBBB");
        submit_and_wait(lat);
        checks++; if (result !== 10'b01_11_11_01_01) begin failures++; $display("FAIL dup_bbbbb got=%b exp=0111110101", result); end
    endtask

    task automatic test_six_wrong();
        int pulses = 0;
        do_reset();
        start_game("CRANE");
        for (int r = 0; r < 6; r++) begin
            checks++; if (row_idx !== 3'(r)) begin failures++; $display("FAIL six_row got=%0d exp=%0d", row_idx, r); end
            enter_word("PAPPY");
            submit_and_wait(lat);
            if (lat == 7) pulses++;
        end
        checks++; if (pulses !== 6) begin failures++; $display("FAIL six_pulses got=%0d exp=6", pulses); end
        checks++; if (done !== 1'b1 || win !== 1'b0 || row_idx !== 3'd5) begin failures++; $display("FAIL six_done got=%b/%b/%0d exp=1/0/5", done, win, row_idx); end
        tick();
        press("Q");
        checks++; if (guess_word !== "PAPPY" || col_idx !== 3'd5 || q_Done !== 1'b1) begin failures++; $display("FAIL six_ignore got=%h/%0d/%b", guess_word, col_idx, q_Done); end
        Ack = 1'b1; tick(); Ack = 1'b0;
    endtask

    task automatic test_same_cycle();
        do_reset();
        start_game("CRANE");
        press("A"); press("B"); press("C");
        letter_in = "Z"; letter_valid = 1'b1; del = 1'b1;
        tick();
        letter_valid = 1'b0; del = 1'b0;
        checks++; if (col_idx !== 3'd2 || guess_word !== {"AB", 24'h202020}) begin failures++; $display("FAIL same_cycle got=%0d/%h exp=2/%h", col_idx, guess_word, {"AB", 24'h202020}); end
    endtask

    task automatic test_reset_in_eval();
        int rv_seen = 0;
        press("C"); press("R"); press("E");
        submit = 1'b1; tick(); submit = 1'b0;
        tick(); tick(); tick();
        checks++; if (q_Eval !== 1'b1) begin failures++; $display("FAIL eval_state got=%b exp=1", q_Eval); end
        do_reset();
        checks++; if (q_I !== 1'b1 || result !== 10'd0 || col_idx !== 3'd0 || guess_word !== {5{8'h20}}) begin failures++; $display("FAIL eval_abort got=%b/%b/%0d/%h", q_I, result, col_idx, guess_word); end
        for (int k = 0; k < 8; k++) begin
            if (result_valid) rv_seen++;
            tick();
        end
        checks++; if (rv_seen !== 0) begin failures++; $display("FAIL eval_abort_pulse got=%0d exp=0", rv_seen); end
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; Ack = 1'b0; letter_valid = 1'b0; del = 1'b0;
        submit = 1'b0; letter_in = 8'h00; target_word = '0;
        test_reset();
        test_crane_win();
        test_delete();
        test_duplicates();
        test_six_wrong();
        test_same_cycle();
        test_reset_in_eval();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/wordle_guess_entry.md
Name: wordle_guess_entry

Overview:
- Downstream consumer of the keyboard cursor stage. Takes the highlighted letter when the player presses select, and assembles a 5-letter guess with delete support.
- On submit, scores the guess against the secret word using Wordle green/yellow/gray rules, including correct duplicate-letter handling.
- Tracks the attempt count and drives the `done` input of the keyboard stage when the game is won or guesses run out.

Parameters:
- MAX_GUESSES, 6, number of attempts before loss; legal range 1..7.
- WORD_LEN, 5, letters per guess; fixed at 5, listed for documentation only.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; sampled on Clk rising edge.
- Start  input  1  level; in QI, latches target_word and begins a game.
- Ack  input  1  level; in QDONE, returns the block to QI.
- letter_in  input  8  ASCII 'A'..'Z' from the keyboard stage (curr_letter).
- letter_valid  input  1  single-cycle pulse; append letter_in.
- del  input  1  single-cycle pulse; remove the last letter.
- submit  input  1  single-cycle pulse; score the current guess.
- target_word  input  40  secret word; letter 0 in [39:32], letter 4 in [7:0].
- guess_word  output  40  letters entered so far, same packing as target_word; unused slots hold 8'h20 (space).
- col_idx  output  3  number of letters entered, 0..5.
- row_idx  output  3  current attempt, 0..MAX_GUESSES-1.
- result  output  10  2 bits per letter, letter 0 in [9:8]: 00 none, 01 gray, 10 yellow, 11 green.
- result_valid  output  1  one-cycle pulse; result is valid for row_idx.
- win  output  1  last scored guess was all green.
- done  output  1  high in QDONE; connects to the keyboard stage `done`.
- q_I, q_Entry, q_Eval, q_Done  output  1 each  one-hot state flags.

Behaviour:
- Reset (synchronous): state QI.
  - guess_word = all 8'h20; col_idx = 0; row_idx = 0; result = 0.
  - result_valid = 0; win = 0; done = 0.
  - Internal target register, green mask and used mask all cleared.
- QI:
  - Start=1 latches target_word, clears guess_word/col_idx/row_idx/result/win, and moves to QENTRY on the next edge.
  - All other inputs are ignored.
- QENTRY, one action per cycle, priority del > submit > letter_valid:
  - del with col_idx>0: col_idx-1; that slot becomes 8'h20.
  - del with col_idx=0: ignored.
  - submit with col_idx=5: move to QEVAL.
  - submit with col_idx<5: ignored.
  - letter_valid with col_idx<5: letter_in written to slot col_idx; col_idx+1.
  - letter_valid with col_idx=5: ignored.
  - letter_in outside 'A'..'Z': ignored.
- QEVAL runs as an internal sub-counter, 7 cycles total (contributes to q_Eval):
  - Cycle 0 (green pass): green[i] = (guess[i]==target[i]); used[i] = green[i]; result[i] = 11 where green, else 01.
  - Cycles 1..5 (yellow pass, i = cycle-1, left to right): if !green[i], find the lowest j with !used[j] and target[j]==guess[i].
    - If found: used[j]=1 and result[i]=10.
    - If not found: result[i] stays 01.
    - The first unmatched occurrence gets yellow; later duplicates stay gray.
  - Cycle 6: result_valid=1 for exactly this cycle; win = &green.
- End of QEVAL:
  - If win, or row_idx = MAX_GUESSES-1: move to QDONE.
  - Otherwise: row_idx+1, col_idx=0, guess_word cleared, move to QENTRY.
- Submit-to-result latency: the submit edge is at t, result_valid is high in cycle t+7. result/win hold until the next QEVAL or Start.
- All inputs other than reset are ignored during QEVAL.
- QDONE:
  - done=1.
  - Ack=1 moves to QI next edge; done drops. result/win hold until the next Start.
- Illegal state encoding: recover to QI on the next edge.
- reset asserted mid-QEVAL or mid-QENTRY: aborts immediately to reset values; no result_valid pulse.

Test Plan:
- Target "CRANE"; Start; enter C,R,A,N,E; submit -> result_valid 7 cycles later; result=10'b1111111111; win=1; done=1; Ack -> q_I=1.
- Enter A,B,C then del twice, then D -> guess_word="AD   "; col_idx=2; submit ignored, state stays QENTRY.
- Target "APPLE", guess "PAPPY" -> result = P yellow, A yellow, P green, P gray, Y gray = 10_10_11_01_01.
- Target "ABBEY", guess "BBBBB" -> only positions 1,2 green, rest gray: 01_11_11_01_01.
- Six wrong guesses -> row_idx 0..5, six result_valid pulses, done=1 and win=0 after the sixth; a 7th letter_valid is ignored.
- letter_valid+del in the same cycle at col_idx=3 -> col_idx=2; reset during QEVAL -> all outputs at reset values next cycle, no result_valid.
